pwm_multi_channel: RTL and testbench
====================================

# pwm_multi_channel

Multi-channel, parametrised successor to the single-channel PWM generator. It drives CHANNELS PWM outputs from one shared period counter, with edge-aligned or center-aligned counting and per-channel output polarity. Period, duty and mode are double-buffered so updates take effect only at a period boundary. It sits between the register/input interface of the top-level tile and the `uo_out` pins.

## Interface
- `WIDTH`, default 8: counter, period and duty width in bits.
- `CHANNELS`, default 4: number of PWM outputs.

- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: run the counter; low idles all outputs.
- `load` input 1: single-cycle strobe that captures `max_value`, `duty` and `center_mode` into the shadow set.
- `max_value` input WIDTH: period limit M.
- `duty` input CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `center_mode` input 1: 0 = edge-aligned, 1 = center-aligned.
- `invert` input CHANNELS: per-channel output polarity. Live, not shadowed.
- `pwm_out` output CHANNELS: registered PWM outputs.
- `period_start` output 1: registered; high for the first cycle of every period.
- `update_pending` output 1: shadow set is loaded but not yet applied.

## Operation
- **Registers**
  - Counter `cnt` (WIDTH bits) and direction `dir` (up/down).
  - Active set: M_a, duty_a[i], mode_a.
  - Shadow set: M_s, duty_s[i], mode_s, plus a pending flag.
- **Edge mode count sequence:** 0, 1, …, M_a, then back to 0. Period is M_a+1 cycles.
- **Center mode count sequence:** up 0…M_a, then down M_a−1…1, then 0 again. Period is 2·M_a cycles. If M_a=0, the counter stays at 0 and the period is 1 cycle.
- **Last cycle of a period (EOP)**
  - Edge mode: `cnt`==M_a.
  - Center mode: (M_a≤1 and `cnt`==M_a), or (`dir`==down and `cnt`==1).
- **Direction:** in center mode, `dir` flips to down on the cycle `cnt`==M_a (when M_a≥2).
- **At EOP with `enable`=1**
  - `cnt`←0 and `dir`←up.
  - If pending: active set ← shadow set, pending cleared.
- **`load` behaviour**
  - `load`=1 captures the inputs into the shadow set and sets pending.
  - If `load` coincides with EOP, the loaded values go directly to the active set at that edge and pending stays 0.
  - A second `load` before the boundary overwrites the shadow set; last write wins.
- **Comparator:** `raw[i]` = (`cnt` < duty_a[i]) as an unsigned WIDTH-bit compare.
  - duty_a=0 gives constant low.
  - duty_a>M_a gives constant high in both modes.
- **Outputs**
  - `pwm_out[i]` ← `enable` ? (`raw[i]` ^ `invert[i]`) : `invert[i]`.
  - `period_start` ← `enable` & (`cnt`==0).
  - `update_pending` = pending flag.
- **`enable`=0**
  - `cnt`←0 and `dir`←up.
  - If pending, the shadow set is applied immediately and pending is cleared.
  - `load` is still accepted and is applied directly to the active set.
  - Counting restarts from 0 on the first cycle `enable`=1.
- **Reset**
  - `cnt`=0, `dir`=up.
  - Active and shadow sets: M=all-ones, duty=0, mode=edge.
  - pending=0.
  - `pwm_out`=0, `period_start`=0, `update_pending`=0.

## Timing
- **Reset:** asynchronous assert clears all registers immediately. Deassert is synchronous to the next `clk` edge.
- **Output latency:** `pwm_out` and `period_start` lag the counter value by 1 cycle, since both are registered from `cnt`.
- **Load latency:** new settings affect `cnt` from the first cycle after the EOP edge. They appear on `pwm_out` one cycle after that.
- **`update_pending`:** rises the cycle after a `load` strobe. Falls the cycle after the applying edge.
- **`invert`:** a change is visible on `pwm_out` after 1 cycle, with no boundary synchronisation.
- **Reset mid-period:** all state is discarded and the shadow set is not applied.

## Test plan
- **Reset mid-run:** drop `rst_n` with `enable`=1, M=9, duty0=5 → `pwm_out`=0000 and `period_start`=0 immediately, before any clock edge; `cnt`=0 after release.
- **Edge mode:** M=9, duty={0,3,10,255}, `load`, `enable` → period 10, `period_start` every 10 cycles. Per period, ch0 high 0 cycles, ch1 high 3 cycles (`cnt` 0–2), ch2 and ch3 high 10 cycles.
- **Center mode:** M=4, duty0=2 → period 8, `cnt` sequence 0,1,2,3,4,3,2,1. ch0 high 3 of 8 cycles. `period_start` every 8 cycles.
- **Degenerate periods**
  - M=0 edge with duty0=1 → `period_start` constantly 1 and ch0 constantly 1.
  - M=1 center → period 2.
- **Shadow update:** M=9, duty0=3. `load` duty0=7 at `cnt`=4 → rest of that period still ch0 high 3 cycles; `update_pending`=1 until the boundary; next period ch0 high 7 cycles. A `load` issued exactly at `cnt`=9 → applied at that boundary, `update_pending` never rises.
- **Enable and invert:** `invert`=0001 with `enable`=0 → `pwm_out`=0001 after 1 cycle. Raise `enable` → `period_start`=1 one cycle later and `cnt` restarts at 0.

Source files
------------

// File: rtl/pwm_multi_channel_if.sv
// Control/status bundle between the tile register block and the PWM generator.
// The master side drives settings; the slave (PWM core) returns outputs.
interface pwm_multi_channel_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                         enable;
  logic                         load;
  logic [WIDTH-1:0]             max_value;
  logic [CHANNELS*WIDTH-1:0]    duty;
  logic                         center_mode;
  logic [CHANNELS-1:0]          invert;
  logic [CHANNELS-1:0]          pwm_out;
  logic                         period_start;
  logic                         update_pending;

  modport master (
    output enable, load, max_value, duty, center_mode, invert,
    input  pwm_out, period_start, update_pending
  );

  modport slave (
    input  enable, load, max_value, duty, center_mode, invert,
    output pwm_out, period_start, update_pending
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared edge/center-aligned period counter,
// double-buffered period/duty/mode applied at period boundaries, live polarity.
module pwm_multi_channel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pwm_multi_channel_if.slave     bus
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  dir_e                dir_q, dir_d;

  logic [WIDTH-1:0]    maxAct_q, maxAct_d;
  logic [WIDTH-1:0]    dutyAct_q [CHANNELS];
  logic [WIDTH-1:0]    dutyAct_d [CHANNELS];
  logic                modeAct_q, modeAct_d;

  logic [WIDTH-1:0]    maxShd_q, maxShd_d;
  logic [WIDTH-1:0]    dutyShd_q [CHANNELS];
  logic [WIDTH-1:0]    dutyShd_d [CHANNELS];
  logic                modeShd_q, modeShd_d;
  logic                pending_q, pending_d;

  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                periodStart_q, periodStart_d;

  logic                eop;
  logic                boundary;

  // Center mode ends a period on the way back down at 1, except for the
  // degenerate M<=1 periods that never turn around.
  always_comb begin
    eop = 1'b0;
    if (modeAct_q) begin
      eop = ((maxAct_q <= WIDTH'(1)) && (cnt_q == maxAct_q)) ||
            ((dir_q == DIR_DOWN) && (cnt_q == WIDTH'(1)));
    end else begin
      eop = (cnt_q == maxAct_q);
    end
  end

  assign boundary = !bus.enable || eop;

  always_comb begin
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    maxAct_d  = maxAct_q;
    modeAct_d = modeAct_q;
    dutyAct_d = dutyAct_q;
    maxShd_d  = maxShd_q;
    modeShd_d = modeShd_q;
    dutyShd_d = dutyShd_q;
    pending_d = pending_q;

    if (bus.load) begin
      maxShd_d  = bus.max_value;
      modeShd_d = bus.center_mode;
      for (int i = 0; i < CHANNELS; i++) begin
        dutyShd_d[i] = bus.duty[i*WIDTH +: WIDTH];
      end
    end

    if (boundary) begin
      cnt_d     = '0;
      dir_d     = DIR_UP;
      pending_d = 1'b0;
      // A load landing on the boundary bypasses the shadow and wins over it.
      if (bus.load) begin
        maxAct_d  = bus.max_value;
        modeAct_d = bus.center_mode;
        for (int i = 0; i < CHANNELS; i++) begin
          dutyAct_d[i] = bus.duty[i*WIDTH +: WIDTH];
        end
      end else if (pending_q) begin
        maxAct_d  = maxShd_q;
        modeAct_d = modeShd_q;
        dutyAct_d = dutyShd_q;
      end
    end else begin
      if (bus.load) begin
        pending_d = 1'b1;
      end
      if (!modeAct_q) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == maxAct_q) begin
          dir_d = DIR_DOWN;
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // Outputs are registered from the current count, so they trail cnt by one cycle.
  always_comb begin
    pwm_d = bus.invert;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.enable) begin
        pwm_d[i] = (cnt_q < dutyAct_q[i]) ^ bus.invert[i];
      end
    end
    periodStart_d = bus.enable && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      dir_q         <= DIR_UP;
      maxAct_q      <= '1;
      modeAct_q     <= 1'b0;
      maxShd_q      <= '1;
      modeShd_q     <= 1'b0;
      pending_q     <= 1'b0;
      pwm_q         <= '0;
      periodStart_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        dutyAct_q[i] <= '0;
        dutyShd_q[i] <= '0;
      end
    end else begin
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      maxAct_q      <= maxAct_d;
      modeAct_q     <= modeAct_d;
      maxShd_q      <= maxShd_d;
      modeShd_q     <= modeShd_d;
      pending_q     <= pending_d;
      pwm_q         <= pwm_d;
      periodStart_q <= periodStart_d;
      for (int i = 0; i < CHANNELS; i++) begin
        dutyAct_q[i] <= dutyAct_d[i];
        dutyShd_q[i] <= dutyShd_d[i];
      end
    end
  end

  assign bus.pwm_out        = pwm_q;
  assign bus.period_start   = periodStart_q;
  assign bus.update_pending = pending_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: table of period/duty configurations
// with hand-computed per-period high counts, plus reset, shadow and enable sequences.
module tb_pwm_multi_channel;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;

  logic clk;
  logic rst_n;

  pwm_multi_channel_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  maxV;
    logic [31:0] duty;
    logic        center;
    logic [3:0]  inv;
    int          period;
    logic [31:0] highs;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic loadIdle(input logic [7:0] maxV, input logic [31:0] duty,
                          input logic center, input logic [3:0] inv);
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    @(negedge clk);
    bus.max_value   = maxV;
    bus.duty        = duty;
    bus.center_mode = center;
    bus.invert      = inv;
    bus.load        = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int hi [CHANNELS];
    int psCount;
    loadIdle(v.maxV, v.duty, v.center, v.inv);
    checkOutput({v.name, " idle pwm"}, 32'(bus.pwm_out), 32'(v.inv));
    checkOutput({v.name, " idle pending"}, 32'(bus.update_pending), 32'd0);
    bus.enable = 1'b1;
    @(negedge clk);
    checkOutput({v.name, " first period_start"}, 32'(bus.period_start), 32'd1);
    for (int c = 0; c < CHANNELS; c++) hi[c] = 0;
    psCount = 0;
    for (int k = 0; k < v.period; k++) begin
      for (int c = 0; c < CHANNELS; c++) hi[c] += int'(bus.pwm_out[c]);
      psCount += int'(bus.period_start);
      @(negedge clk);
    end
    for (int c = 0; c < CHANNELS; c++) begin
      checkOutput($sformatf("%s ch%0d high", v.name, c), 32'(hi[c]), 32'(v.highs[c*8 +: 8]));
    end
    checkOutput({v.name, " period_start per period"}, 32'(psCount), 32'd1);
    checkOutput({v.name, " next period_start"}, 32'(bus.period_start), 32'd1);
  endtask

  logic ch0Log  [30];
  logic pendLog [30];
  logic psLog   [30];

  initial begin
    vecs[0] = '{"edge M9",     8'd9, 32'hFF0A_0300, 1'b0, 4'b0000, 10, {8'd10, 8'd10, 8'd3, 8'd0}};
    vecs[1] = '{"center M4",   8'd4, 32'h0405_0002, 1'b1, 4'b0000,  8, {8'd7,  8'd8,  8'd0, 8'd3}};
    vecs[2] = '{"edge M0",     8'd0, 32'h0001_0001, 1'b0, 4'b0000,  1, {8'd0,  8'd1,  8'd0, 8'd1}};
    vecs[3] = '{"center M1",   8'd1, 32'h0100_0201, 1'b1, 4'b0000,  2, {8'd1,  8'd0,  8'd2, 8'd1}};
    vecs[4] = '{"center M0",   8'd0, 32'hC800_0100, 1'b1, 4'b0000,  1, {8'd1,  8'd0,  8'd1, 8'd0}};
    vecs[5] = '{"edge M3 inv", 8'd3, 32'h0403_0201, 1'b0, 4'b1010,  4, {8'd0,  8'd3,  8'd2, 8'd1}};
    vecs[6] = '{"center M2",   8'd2, 32'h0003_0201, 1'b1, 4'b0000,  4, {8'd0,  8'd4,  8'd3, 8'd1}};

    rst_n           = 1'b0;
    bus.enable      = 1'b0;
    bus.load        = 1'b0;
    bus.max_value   = '0;
    bus.duty        = '0;
    bus.center_mode = 1'b0;
    bus.invert      = '0;

    #2;
    checkOutput("reset pwm_out", 32'(bus.pwm_out), 32'd0);
    checkOutput("reset period_start", 32'(bus.period_start), 32'd0);
    checkOutput("reset update_pending", 32'(bus.update_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a running period.
    loadIdle(8'd9, 32'h0000_0005, 1'b0, 4'b0000);
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("pre-reset ch0", 32'(bus.pwm_out[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset pwm_out", 32'(bus.pwm_out), 32'd0);
    checkOutput("async reset period_start", 32'(bus.period_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset period_start", 32'(bus.period_start), 32'd1);
    checkOutput("post-reset pwm_out", 32'(bus.pwm_out), 32'd0);
    @(negedge clk);
    checkOutput("post-reset count advanced", 32'(bus.period_start), 32'd0);

    for (int v = 0; v < 7; v++) applyStimulus(vecs[v]);

    // Shadow update: load mid-period, then a load landing exactly on EOP.
    loadIdle(8'd9, 32'h0000_0003, 1'b0, 4'b0000);
    bus.enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      ch0Log[k]  = bus.pwm_out[0];
      pendLog[k] = bus.update_pending;
      psLog[k]   = bus.period_start;
      if (k == 3) begin
        bus.duty = 32'h0000_0007;
        bus.load = 1'b1;
      end else if (k == 18) begin
        bus.duty = 32'h0000_0005;
        bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    begin
      int h0, h1, h2, anyPend;
      h0 = 0; h1 = 0; h2 = 0; anyPend = 0;
      for (int k = 0; k < 10; k++) begin
        h0 += int'(ch0Log[k]);
        h1 += int'(ch0Log[k+10]);
        h2 += int'(ch0Log[k+20]);
      end
      for (int k = 10; k < 30; k++) anyPend += int'(pendLog[k]);
      checkOutput("shadow old duty kept", 32'(h0), 32'd3);
      checkOutput("shadow new duty applied", 32'(h1), 32'd7);
      checkOutput("eop load applied", 32'(h2), 32'd5);
      checkOutput("pending before load", 32'(pendLog[3]), 32'd0);
      checkOutput("pending after load", 32'(pendLog[4]), 32'd1);
      checkOutput("pending held", 32'(pendLog[8]), 32'd1);
      checkOutput("pending cleared", 32'(pendLog[9]), 32'd0);
      checkOutput("eop load no pending", 32'(anyPend), 32'd0);
      checkOutput("shadow period_start 10", 32'(psLog[10]), 32'd1);
      checkOutput("shadow period_start 20", 32'(psLog[20]), 32'd1);
    end

    // Idle polarity, then restart from 0 when enable rises.
    bus.enable = 1'b0;
    bus.invert = 4'b0000;
    @(negedge clk);
    bus.invert = 4'b0001;
    @(negedge clk);
    checkOutput("idle invert pwm", 32'(bus.pwm_out), 32'b0001);
    checkOutput("idle period_start", 32'(bus.period_start), 32'd0);
    bus.enable = 1'b1;
    @(negedge clk);
    checkOutput("enable period_start", 32'(bus.period_start), 32'd1);
    @(negedge clk);
    checkOutput("enable second cycle", 32'(bus.period_start), 32'd0);
    bus.invert = 4'b1111;
    @(negedge clk);
    checkOutput("live invert", 32'(bus.pwm_out), 32'b1110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
